// File: rtl/exalu_seq.sv
// Wide execute-stage ALU: single-cycle add/xor/extract/shift-in ops plus
// ECB/CBC block-cipher ops sequenced through an external engine.
module exalu_seq #(
  parameter int WIDTH   = 256,
  parameter int BLOCK   = 128,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] exaluOut,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             engine_start,
  output logic             engine_dir,
  output logic [BLOCK-1:0] engine_data,
  output logic [BLOCK-1:0] engine_key,
  input  logic             engine_busy,
  input  logic [BLOCK-1:0] engine_result
);
  // state | meaning
  // IDLE  | accept ops; single-cycle ops complete here
  // ISSUE | pulse engine_start with latched operands
  // WAIT  | wait for engine idle or timeout
  // DONE  | present result for one cycle
  // DRAIN | request withdrawn; let the engine finish, discard result
  // REARM | wait for we to drop so a held request is not re-run
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN, S_REARM} state_t;

  localparam int LW = $clog2(WIDTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [BLOCK-1:0] data_q, key_q, blk_q, iv_q, out_q;
  logic             err_q;
  logic [CW-1:0]    cnt_q;

  logic             is_mc;
  logic [WIDTH-1:0] alu_res, out_c;
  logic             busy_c, done_c, err_c, start_c;

  assign is_mc = (alucontrol == 4'h1) || (alucontrol == 4'h2) ||
                 (alucontrol == 4'h8) || (alucontrol == 4'h9);

  always_comb begin
    alu_res = '0;
    case (alucontrol)
      4'h0: alu_res = D1 + D2;
      // any shift amount at or beyond the width gives zero
      4'h3, 4'h6: if ((D2 >> LW) == '0) alu_res = WIDTH'(32'(D1 >> D2[LW-1:0]));
      4'h5: alu_res = (D1 << 8) | WIDTH'(D2[7:0]);
      4'h7: alu_res = D1 ^ D2;
      4'hB: alu_res = WIDTH'(iv_q);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    start_c = 1'b0;
    out_c   = '0;
    case (state_q)
      S_IDLE: begin
        if (we && is_mc) begin
          busy_c  = 1'b1;
          state_d = S_ISSUE;
        end else begin
          done_c = we;
          out_c  = alu_res;
        end
      end
      S_ISSUE: begin
        busy_c  = 1'b1;
        start_c = 1'b1;
        state_d = we ? S_WAIT : S_DRAIN;
      end
      S_WAIT: begin
        busy_c = 1'b1;
        if (!we) state_d = S_DRAIN;
        else if (!engine_busy || cnt_q == TC) state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        err_c   = err_q;
        out_c   = WIDTH'(out_q);
        state_d = S_REARM;
      end
      S_DRAIN: begin
        busy_c = 1'b1;
        if (!engine_busy) state_d = S_IDLE;
      end
      S_REARM: if (!we) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      iv_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (we && is_mc) begin
            op_q   <= alucontrol;
            key_q  <= D2[BLOCK-1:0];
            blk_q  <= D1[BLOCK-1:0];
            data_q <= (alucontrol == 4'h8) ? (D1[BLOCK-1:0] ^ iv_q) : D1[BLOCK-1:0];
          end else if (we && alucontrol == 4'hA) begin
            iv_q <= D1[BLOCK-1:0];
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          if (we) begin
            if (!engine_busy) begin
              err_q <= 1'b0;
              out_q <= (op_q == 4'h9) ? (engine_result ^ iv_q) : engine_result;
              if (op_q == 4'h8) iv_q <= engine_result;
              else if (op_q == 4'h9) iv_q <= blk_q;
            end else if (cnt_q == TC) begin
              err_q <= 1'b1;
              out_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // all outputs forced low while reset is held
  assign exaluOut     = reset_n ? out_c : '0;
  assign busy         = reset_n & busy_c;
  assign done         = reset_n & done_c;
  assign error        = reset_n & err_c;
  assign engine_start = reset_n & start_c;
  assign engine_dir   = reset_n & ((op_q == 4'h2) || (op_q == 4'h9));
  assign engine_data  = reset_n ? data_q : '0;
  assign engine_key   = reset_n ? key_q : '0;

endmodule

// File: tb/tb_exalu_seq.sv
// Directed bench for exalu_seq: vector table for single-cycle ops and
// hand-written sequences against a latency-programmable engine model.
module tb_exalu_seq;
  localparam int W = 256;
  localparam logic [W-1:0] ONES = '1;

  logic           clock = 1'b0;
  logic           reset_n, we;
  logic [3:0]     alucontrol;
  logic [W-1:0]   D1, D2, exaluOut;
  logic           busy, done, error, engine_start, engine_dir, engine_busy;
  logic [127:0]   engine_data, engine_key, engine_result;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clock = ~clock;

  exalu_seq #(.WIDTH(256), .BLOCK(128), .TIMEOUT(64)) dut (
    .clock(clock), .reset_n(reset_n), .we(we), .alucontrol(alucontrol),
    .D1(D1), .D2(D2), .exaluOut(exaluOut), .busy(busy), .done(done),
    .error(error), .engine_start(engine_start), .engine_dir(engine_dir),
    .engine_data(engine_data), .engine_key(engine_key),
    .engine_busy(engine_busy), .engine_result(engine_result)
  );

  // engine model: busy for eng_lat cycles starting the cycle after start
  int           eng_lat;
  int           eng_cnt;
  logic [127:0] eng_res;
  always @(posedge clock) begin
    if (!reset_n) eng_cnt <= 0;
    else if (engine_start) eng_cnt <= eng_lat;
    else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
  end
  assign engine_busy   = (eng_cnt != 0);
  assign engine_result = eng_res;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] exp;
  } vec_t;
  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  int           r_start, r_nstart, r_done, r_blow;
  logic [W-1:0] r_out;
  logic         r_err, r_dir;
  logic [127:0] r_data, r_key;

  // runs one multi-cycle op; cycle 0 is the first cycle with we high
  task automatic run_mc(input logic [3:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input int lat, input logic [127:0] res, input int hold);
    eng_lat = lat; eng_res = res;
    alucontrol = op; D1 = d1; D2 = d2; we = 1'b1;
    r_start = -1; r_nstart = 0; r_done = -1; r_blow = -1;
    r_out = '0; r_err = 1'b0; r_dir = 1'b0; r_data = '0; r_key = '0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      if (engine_start) begin
        r_nstart++;
        if (r_start < 0) begin
          r_start = c; r_data = engine_data; r_key = engine_key; r_dir = engine_dir;
        end
      end
      if (!busy && r_blow < 0) r_blow = c;
      if (done && r_done < 0) begin
        r_done = c; r_out = exaluOut; r_err = error;
      end
      tick;
      if (c == 0) begin D1 = ~d1; D2 = ~d2; end
      if (r_done >= 0 && c >= r_done + hold) we = 1'b0;
      if (r_done >= 0 && c >= r_done + hold + 2) break;
    end
    we = 1'b0;
  endtask

  task automatic read_iv(input string name, input logic [W-1:0] exp);
    alucontrol = 4'hB; D1 = '0; D2 = '0; we = 1'b1;
    @(negedge clock);
    chk(name, exaluOut, exp);
    tick;
    we = 1'b0;
    tick;
  endtask

  initial begin
    vecs[0]  = '{4'h0, ONES, 256'd1, 256'd0};
    vecs[1]  = '{4'h0, 256'd5, 256'd7, 256'd12};
    vecs[2]  = '{4'h3, ONES, 256'd256, 256'd0};
    vecs[3]  = '{4'h3, 256'h0123456789ABCDEF, 256'd4, 256'h789ABCDE};
    vecs[4]  = '{4'h6, {4'hF, 252'h0}, 256'd252, 256'hF};
    vecs[5]  = '{4'h3, ONES, 256'h1_0000_0000, 256'd0};
    vecs[6]  = '{4'h5, 256'd1, 256'h1ab, 256'h1ab};
    vecs[7]  = '{4'h5, {8'hAA, 240'h0, 8'h01}, 256'hFF34, 256'h134};
    vecs[8]  = '{4'h7, 256'hF0F0, 256'h0FF0, 256'hFF00};
    vecs[9]  = '{4'hC, ONES, ONES, 256'd0};
    vecs[10] = '{4'hB, ONES, ONES, 256'd0};
    vecs[11] = '{4'hA, {ONES[127:0], 128'h55}, 256'd0, 256'd0};
    vecs[12] = '{4'hB, 256'd0, 256'd0, 256'h55};

    reset_n = 1'b0; we = 1'b1; alucontrol = 4'h0; D1 = 256'd3; D2 = 256'd4;
    eng_lat = 0; eng_res = '0;
    @(negedge clock);
    chk("reset_out", exaluOut, '0);
    chk("reset_ctl", {busy, done, error, engine_start, engine_dir}, '0);
    tick; tick;
    reset_n = 1'b1; we = 1'b0;
    tick;

    for (int i = 0; i < NV; i++) begin
      alucontrol = vecs[i].op; D1 = vecs[i].d1; D2 = vecs[i].d2; we = 1'b1;
      @(negedge clock);
      chk($sformatf("vec%0d_out", i), exaluOut, vecs[i].exp);
      chk($sformatf("vec%0d_busy_done", i), {busy, done}, 2'b01);
      tick;
    end
    we = 1'b0;
    tick;

    // ECB encrypt, engine latency 10
    run_mc(4'h1, {128'hABAB, 128'h1234}, {128'h7777, 128'hCAFE}, 10, 128'hDEAD, 0);
    chk("ecb_start_cyc", r_start, 1);
    chk("ecb_nstart", r_nstart, 1);
    chk("ecb_done_cyc", r_done, 13);
    chk("ecb_out", r_out, 256'hDEAD);
    chk("ecb_busy_low", r_blow, 13);
    chk("ecb_data", r_data, 128'h1234);
    chk("ecb_key", r_key, 128'hCAFE);
    chk("ecb_dir", r_dir, 0);

    // ECB decrypt, zero engine latency
    run_mc(4'h2, 256'h42, 256'h9, 0, 128'h5150, 0);
    chk("ecbd_done_cyc", r_done, 3);
    chk("ecbd_out_err", {r_out, r_err}, {256'h5150, 1'b0});
    chk("ecbd_dir", r_dir, 1);

    // CBC chain with IV = 0x55
    run_mc(4'h8, 256'h0F, 256'h1, 2, 128'h1234, 0);
    chk("cbce_data", r_data, 128'h5A);
    chk("cbce_out", r_out, 256'h1234);
    read_iv("cbce_iv", 256'h1234);
    run_mc(4'h9, 256'h77, 256'h2, 1, 128'h11, 0);
    chk("cbcd_data", r_data, 128'h77);
    chk("cbcd_dir", r_dir, 1);
    chk("cbcd_out", r_out, 256'h1225);
    read_iv("cbcd_iv", 256'h77);

    // abort: we dropped at cycle 4, engine busy through cycle 9
    begin
      int saw_done = 0;
      int blow = -1;
      int nst = 0;
      eng_lat = 8; eng_res = 128'h44;
      alucontrol = 4'h9; D1 = 256'h99; D2 = 256'h3; we = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        if (done) saw_done++;
        if (engine_start) nst++;
        if (!busy && blow < 0) blow = c;
        tick;
        if (c == 3) we = 1'b0;
      end
      chk("drain_no_done", saw_done, 0);
      chk("drain_busy_low", blow, 11);
      chk("drain_nstart", nst, 1);
    end
    read_iv("drain_iv", 256'h77);
    run_mc(4'h1, 256'h5, 256'h6, 2, 128'hBEEF, 0);
    chk("post_drain_done", r_done, 5);
    chk("post_drain_out", r_out, 256'hBEEF);

    // request held 3 cycles after done must not restart
    run_mc(4'h1, 256'h8, 256'h9, 3, 128'h3, 3);
    chk("hold_done_cyc", r_done, 6);
    chk("hold_nstart", r_nstart, 1);

    // timeout with engine busy far longer than TIMEOUT
    run_mc(4'h8, 256'h21, 256'h22, 200, 128'h999, 0);
    chk("tmo_done_cyc", r_done, 66);
    chk("tmo_err", r_err, 1);
    chk("tmo_out", r_out, 256'd0);
    read_iv("tmo_iv", 256'h77);

    // reset during WAIT
    eng_lat = 50; eng_res = 128'h1;
    alucontrol = 4'h8; D1 = 256'h3C; D2 = 256'h5; we = 1'b1;
    for (int c = 0; c < 5; c++) tick;
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_wait_ctl", {busy, done, error, engine_start, engine_dir}, '0);
    chk("rst_wait_data", {engine_data, engine_key}, '0);
    tick;
    reset_n = 1'b1; we = 1'b0;
    @(negedge clock);
    chk("rst_idle_busy", {busy, engine_busy}, '0);
    tick;
    read_iv("rst_iv", 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/exalu_seq.md
# exalu_seq

Parametrised successor to the extended 256-bit ALU in the `shrv32` execute stage. It keeps the single-cycle wide ops: add, xor, word extract and byte shift-in. It sequences block-cipher operations through an external cipher engine using a registered FSM, a timeout and an abort path. It adds CBC chaining with an internal IV register, so the pipeline no longer carries the IV.

## Interface
Parameters:
- `WIDTH`, 256: data path width; must be a power of two and at least `BLOCK`.
- `BLOCK`, 128: cipher block and key width.
- `TIMEOUT`, 64: maximum number of WAIT cycles before an error is raised; must be at least 2.

Ports:
- `clock`, in, 1: the only clock; all state updates on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `we`, in, 1: op request; held high by the pipeline until `done`.
- `alucontrol`, in, 4: opcode.
- `D1`, in, `WIDTH`: operand 1.
- `D2`, in, `WIDTH`: operand 2.
- `exaluOut`, out, `WIDTH`: result.
- `busy`, out, 1: stall request to the pipeline.
- `done`, out, 1: result valid this cycle.
- `error`, out, 1: the op completing this cycle timed out.
- `engine_start`, out, 1: one-cycle start pulse to the cipher engine.
- `engine_dir`, out, 1: 0 = encrypt, 1 = decrypt.
- `engine_data`, out, `BLOCK`: block sent to the engine.
- `engine_key`, out, `BLOCK`: key sent to the engine.
- `engine_busy`, in, 1: engine busy; rises the cycle after `engine_start`.
- `engine_result`, in, `BLOCK`: engine result; valid while `engine_busy` is 0.

## Operation
Single-cycle ops are combinational. For these, `done` equals `we` and `busy` is 0.
- `0`: `D1 + D2`, modulo 2^`WIDTH`.
- `3` and `6`: `(D1 >> D2) & 32'hffffffff`. Any nonzero `D2` bit at or above log2(`WIDTH`) yields 0.
- `5`: `(D1 << 8) | D2[7:0]`.
- `7`: `D1 ^ D2`.
- `A`: IV is loaded from `D1[BLOCK-1:0]` at the edge; `exaluOut` = 0.
- `B`: `exaluOut` = zero-extended IV.
- Other opcodes: `exaluOut` = 0.

Multi-cycle ops. The key is always `D2[BLOCK-1:0]`.
- `1`, ECB encrypt: data = `D1[BLOCK-1:0]`; out = result.
- `2`, ECB decrypt: data = `D1[BLOCK-1:0]`; out = result.
- `8`, CBC encrypt: data = `D1[BLOCK-1:0]` ^ IV; out = result; IV <= result.
- `9`, CBC decrypt: data = `D1[BLOCK-1:0]`; out = result ^ IV; IV <= `D1[BLOCK-1:0]` (the value latched at ISSUE).

All multi-cycle results are zero-extended to `WIDTH`.

FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN, REARM.
- IDLE: on `we` with a multi-cycle op and the block armed, go to ISSUE. Latch the opcode, data, key and `D1` block.
- ISSUE: `engine_start` = 1 for exactly this cycle; go to WAIT. Clear the WAIT counter.
- WAIT: on `engine_busy` = 0, capture `engine_result` into the output register, update the IV per opcode, and go to DONE.
  - If the counter reaches `TIMEOUT - 1` while still busy, go to DONE with the error flag set. The output register is zeroed and the IV is left unchanged.
  - If `we` falls in ISSUE or WAIT, go to DRAIN.
- DONE: `done` = 1, `busy` = 0, `exaluOut` = output register, `error` = error flag. Go to REARM.
- DRAIN: wait for `engine_busy` = 0, then go to IDLE. The result is discarded, the IV is unchanged and `done` is never raised.
- REARM: go to IDLE once `we` = 0. A request held high after DONE is never re-executed.

`busy` = 1 in ISSUE, WAIT and DRAIN, and in IDLE when `we` is high with a multi-cycle op. It is 0 in DONE and REARM.

The engine outputs are driven from the latched registers, not from the live `D1`/`D2`.

## Timing
- Reset (`reset_n` = 0 at an edge): state becomes IDLE, IV becomes 0, all registers clear.
  - While `reset_n` is low, every output is 0.
  - Reset mid-op abandons the engine; the engine must be reset by the same `reset_n`.
- Single-cycle ops complete with zero latency.
- Multi-cycle latency, with `we` rising at cycle 0 and the engine busy for L ≥ 0 cycles:
  - `engine_start` at cycle 1;
  - `done` at cycle L+3;
  - with L = 0, `done` is at cycle 3.
- Timeout: `done` with `error` = 1 at cycle `TIMEOUT`+2.
- `alucontrol`, `D1` and `D2` may change after IDLE without effect on the running op.
- The opcode `A` write and the CBC IV update never coincide, because only one op is active at a time.

## Test plan
- Op `0` with `D1` = 2^256−1 and `D2` = 1 → `exaluOut` = 0. Op `3` with `D2` = 256 → 0. Op `5` with `D1` = 1 and `D2` = `0x1ab` → `0x1ab`.
- Op `1` with an engine model of L = 10 returning `0xDEAD` → `engine_start` only at cycle 1; `done` at cycle 13 with `exaluOut` = `0xDEAD`; `busy` high from cycle 0 to 12.
- Op `A` with `D1` = `0x55`, then op `8` with `D1` = `0x0F` → `engine_data` = `0x5A`; after done, op `B` reads the engine result. Then op `9` with `D1` = `0x77` and engine result `0x11` → out = `0x11` ^ old IV; IV = `0x77`.
- Engine held busy forever, `TIMEOUT` = 64 → `done` and `error` at cycle 66; `exaluOut` = 0; IV unchanged.
- `we` dropped at cycle 4 with the engine busy until cycle 9 → no `done`; `busy` falls after the engine goes idle; the next op runs normally.
- `we` held high for 3 cycles after `done` → no second `engine_start`. `reset_n` low during WAIT → IDLE and IV = 0 after the edge.
